ccip_avmm_mmio_csr_slave: RTL

Avalon-MM slave CSR block that sits directly downstream of the CCI-P MMIO-to-Avalon bridge, on its avmm_* master port. It implements the AFU's device feature header, AFU ID, scratch, cycle counter, status and read-count registers. It returns exactly one readdatavalid pulse per accepted read, at a fixed latency, because the upstream TID tracking pairs responses with requests in order and cannot tolerate dropped or extra responses.

---
 rtl/ccip_avmm_pkg.sv | 21 ++
 rtl/avmm_rsp_delay_pipe.sv | 36 +++
 rtl/ccip_avmm_mmio_csr_slave.sv | 104 ++++++++++
 3 files changed

// File: rtl/ccip_avmm_pkg.sv
// Shared CSR map, status layout and data width for the CCI-P MMIO Avalon-MM CSR slave.
package ccip_avmm_pkg;

  localparam int CSR_DATA_WIDTH = 64;

  localparam logic [5:0] CSR_DFH         = 6'h00;
  localparam logic [5:0] CSR_AFU_ID_L    = 6'h08;
  localparam logic [5:0] CSR_AFU_ID_H    = 6'h10;
  localparam logic [5:0] CSR_RSVD        = 6'h18;
  localparam logic [5:0] CSR_SCRATCH     = 6'h20;
  localparam logic [5:0] CSR_CYCLE_COUNT = 6'h28;
  localparam logic [5:0] CSR_STATUS      = 6'h30;
  localparam logic [5:0] CSR_READ_COUNT  = 6'h38;

  typedef struct packed {
    logic protocol_error;
    logic unmapped_read;
    logic unmapped_write;
  } t_csr_status;

endpackage

// File: rtl/avmm_rsp_delay_pipe.sv
// Fixed-delay read response pipe: {valid, data} emerges DEPTH cycles after entry.
// No backpressure; synchronous reset drops every response in flight.
module avmm_rsp_delay_pipe
  import ccip_avmm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_vld,
  input  logic [CSR_DATA_WIDTH-1:0] in_dat,
  output logic                      out_vld,
  output logic [CSR_DATA_WIDTH-1:0] out_dat
);

  logic [DEPTH-1:0]                     vld_q;
  logic [DEPTH-1:0][CSR_DATA_WIDTH-1:0] dat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      dat_q[0] <= in_dat;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/ccip_avmm_mmio_csr_slave.sv
// AFU CSR block on the MMIO bridge's Avalon-MM port: DFH, AFU ID, scratch, counters, status.
// Reads answer exactly once after READ_LATENCY cycles; waitrequest only stalls just after reset.
module ccip_avmm_mmio_csr_slave
  import ccip_avmm_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 18,
  parameter int          READ_LATENCY = 2,
  parameter logic [63:0] DFH_VALUE    = 64'h1000_0000_0000_1000,
  parameter logic [63:0] AFU_ID_L     = 64'h0,
  parameter logic [63:0] AFU_ID_H     = 64'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] avmm_address,
  input  logic                  avmm_read,
  input  logic                  avmm_write,
  input  logic [63:0]           avmm_writedata,
  input  logic [7:0]            avmm_byteenable,
  output logic                  avmm_waitrequest,
  output logic [63:0]           avmm_readdata,
  output logic                  avmm_readdatavalid
);

  logic [CSR_DATA_WIDTH-1:0] scratch;
  logic [CSR_DATA_WIDTH-1:0] cycle_count;
  logic [31:0]               read_count;
  t_csr_status               status;
  t_csr_status               status_set;
  logic [2:0]                status_clr;
  logic [CSR_DATA_WIDTH-1:0] rd_data;
  logic [5:0]                csr_off;
  logic                      mapped;
  logic                      rd_acc;
  logic                      wr_acc;
  logic                      unused_addr_lsb;

  assign unused_addr_lsb = ^avmm_address[2:0];
  assign csr_off = {avmm_address[5:3], 3'b000};
  assign mapped  = (avmm_address[ADDR_WIDTH-1:6] == '0);
  // A simultaneous read+write is served as a read; the write half is discarded.
  assign rd_acc  = avmm_read & ~avmm_waitrequest;
  assign wr_acc  = avmm_write & ~avmm_read & ~avmm_waitrequest;

  always_comb begin
    rd_data = '0;
    if (mapped) begin
      case (csr_off)
        CSR_DFH:         rd_data = DFH_VALUE;
        CSR_AFU_ID_L:    rd_data = AFU_ID_L;
        CSR_AFU_ID_H:    rd_data = AFU_ID_H;
        CSR_SCRATCH:     rd_data = scratch;
        CSR_CYCLE_COUNT: rd_data = cycle_count;
        CSR_STATUS:      rd_data = {61'b0, status};
        CSR_READ_COUNT:  rd_data = {32'b0, read_count};
        default:         rd_data = '0;
      endcase
    end
  end

  always_comb begin
    status_set.protocol_error = avmm_read & avmm_write & ~avmm_waitrequest;
    status_set.unmapped_read  = rd_acc & ~mapped;
    status_set.unmapped_write = wr_acc & ~mapped;
    status_clr = '0;
    if (wr_acc && mapped && csr_off == CSR_STATUS && avmm_byteenable[0])
      status_clr = avmm_writedata[2:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avmm_waitrequest <= 1'b1;
      scratch          <= '0;
      cycle_count      <= '0;
      status           <= '0;
      read_count       <= '0;
    end else begin
      avmm_waitrequest <= 1'b0;
      if (wr_acc && mapped && csr_off == CSR_CYCLE_COUNT)
        cycle_count <= '0;
      else
        cycle_count <= cycle_count + 64'd1;
      for (int i = 0; i < 8; i++) begin
        if (wr_acc && mapped && csr_off == CSR_SCRATCH && avmm_byteenable[i])
          scratch[8*i +: 8] <= avmm_writedata[8*i +: 8];
      end
      // Set wins over a same-cycle clear of the same bit.
      status <= (status & ~status_clr) | status_set;
      if (rd_acc && read_count != 32'hFFFF_FFFF)
        read_count <= read_count + 32'd1;
    end
  end

  avmm_rsp_delay_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rsp_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (rd_acc),
    .in_dat  (rd_data),
    .out_vld (avmm_readdatavalid),
    .out_dat (avmm_readdata)
  );

endmodule
